// File: rtl/uart_receiver_param.sv
// Parametrised UART receive deframer: 2-flop synchroniser, 3-sample mid-bit majority,
// start-glitch rejection, optional parity, 1/2 stop bits, valid/ready output register.
module uart_receiver_param #(
  parameter int CLKS_PER_BAUD = 868,
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic                 parity_err_out,
  output logic                 frame_err_out,
  output logic                 overrun_out,
  output logic                 busy_out
);

  localparam int CW = $clog2(CLKS_PER_BAUD);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BAUD - 1);
  localparam logic [CW-1:0] SMP_A   = CW'(CLKS_PER_BAUD / 2 - 1);
  localparam logic [CW-1:0] SMP_B   = CW'(CLKS_PER_BAUD / 2);
  localparam logic [CW-1:0] SMP_C   = CW'(CLKS_PER_BAUD / 2 + 1);
  localparam logic [3:0] LAST_DATA  = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP  = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;

  state_t               state, state_next;
  logic                 rx_meta, rx_s;
  logic [CW-1:0]        cnt, cnt_next;
  logic [3:0]           idx, idx_next;
  logic [DATA_BITS-1:0] shreg, shreg_next;
  logic                 smp_a, smp_b;
  logic                 perr, perr_next, ferr, ferr_next;
  logic                 deliver, deliver_ferr;
  logic                 maj, decide, wrap;

  // Odd parity expects an odd count of ones across data and parity bit.
  function automatic logic parity_error(input logic [DATA_BITS-1:0] d, input logic p);
    return ((^d) ^ p) != (PARITY == 1);
  endfunction

  assign maj    = (smp_a & smp_b) | (smp_a & rx_s) | (smp_b & rx_s);
  assign decide = (cnt == SMP_C);
  assign wrap   = (cnt == CNT_MAX);

  // Line synchroniser
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

  // Receive state and datapath registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= 4'd0;
      shreg <= '0;
      perr  <= 1'b0;
      ferr  <= 1'b0;
      smp_a <= 1'b1;
      smp_b <= 1'b1;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      idx   <= idx_next;
      shreg <= shreg_next;
      perr  <= perr_next;
      ferr  <= ferr_next;
      smp_a <= (cnt == SMP_A) ? rx_s : smp_a;
      smp_b <= (cnt == SMP_B) ? rx_s : smp_b;
    end
  end

  // Next-state and per-bit decisions
  always_comb begin
    state_next   = state;
    cnt_next     = wrap ? '0 : cnt + CW'(1);
    idx_next     = idx;
    shreg_next   = shreg;
    perr_next    = perr;
    ferr_next    = ferr;
    deliver      = 1'b0;
    deliver_ferr = ferr;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (!rx_s) begin
          state_next = START;
          idx_next   = 4'd0;
          perr_next  = 1'b0;
          ferr_next  = 1'b0;
        end else begin
          state_next = IDLE;
        end
      end
      START: begin
        if (decide && maj) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (wrap) begin
          state_next = DATA;
          idx_next   = 4'd0;
        end else begin
          state_next = START;
        end
      end
      DATA: begin
        if (decide) begin
          shreg_next = {maj, shreg[DATA_BITS-1:1]};
        end else if (wrap) begin
          if (idx == LAST_DATA) begin
            idx_next   = 4'd0;
            state_next = (PARITY != 0) ? PAR : STOP;
          end else begin
            idx_next = idx + 4'd1;
          end
        end else begin
          shreg_next = shreg;
        end
      end
      PAR: begin
        if (decide) begin
          perr_next = parity_error(shreg, maj);
        end else if (wrap) begin
          state_next = STOP;
          idx_next   = 4'd0;
        end else begin
          perr_next = perr;
        end
      end
      STOP: begin
        if (decide) begin
          ferr_next = ferr | ~maj;
          if (idx == LAST_STOP) begin
            // Frame is handed over at mid-stop so back-to-back frames are never missed.
            deliver      = 1'b1;
            deliver_ferr = ferr | ~maj;
            state_next   = maj ? IDLE : BRK;
            cnt_next     = '0;
          end else begin
            state_next = STOP;
          end
        end else if (wrap) begin
          idx_next = idx + 4'd1;
        end else begin
          state_next = STOP;
        end
      end
      BRK: begin
        cnt_next   = '0;
        state_next = rx_s ? IDLE : BRK;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Output register with valid/ready handshake and overrun detection
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      data_out       <= '0;
      valid_out      <= 1'b0;
      parity_err_out <= 1'b0;
      frame_err_out  <= 1'b0;
      overrun_out    <= 1'b0;
      busy_out       <= 1'b0;
    end else begin
      overrun_out <= 1'b0;
      busy_out    <= (state_next != IDLE);
      if (deliver) begin
        if (!valid_out || ready_in) begin
          data_out       <= shreg;
          parity_err_out <= perr;
          frame_err_out  <= deliver_ferr;
          valid_out      <= 1'b1;
        end else begin
          overrun_out <= 1'b1;
        end
      end else if (valid_out && ready_in) begin
        valid_out <= 1'b0;
      end else begin
        valid_out <= valid_out;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver_param.sv
// Directed bench: three receivers (8N1, 8E1, 8N2) at 16 clocks per bit share one
// stimulus line routed to the instance under test.
module tb_uart_receiver_param;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_line = 1'b1;
  int         sel = 0;
  logic       rxl [3];
  logic [7:0] dout [3];
  logic       vld [3], rdy [3], perr [3], ferr [3], ovr [3], busy [3];
  int         acc [3];
  int         ovr_cnt [3];
  logic [7:0] last_d [3];
  logic       last_pe [3], last_fe [3];
  int         n_checks = 0;
  int         n_fail = 0;
  int         a0, o0;

  always #5 clk = ~clk;

  assign rxl[0] = (sel == 0) ? rx_line : 1'b1;
  assign rxl[1] = (sel == 1) ? rx_line : 1'b1;
  assign rxl[2] = (sel == 2) ? rx_line : 1'b1;

  uart_receiver_param #(.CLKS_PER_BAUD(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk_in(clk), .rst_n_in(rst_n), .rx_in(rxl[0]), .data_out(dout[0]), .valid_out(vld[0]),
    .ready_in(rdy[0]), .parity_err_out(perr[0]), .frame_err_out(ferr[0]),
    .overrun_out(ovr[0]), .busy_out(busy[0]));

  uart_receiver_param #(.CLKS_PER_BAUD(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_p (
    .clk_in(clk), .rst_n_in(rst_n), .rx_in(rxl[1]), .data_out(dout[1]), .valid_out(vld[1]),
    .ready_in(rdy[1]), .parity_err_out(perr[1]), .frame_err_out(ferr[1]),
    .overrun_out(ovr[1]), .busy_out(busy[1]));

  uart_receiver_param #(.CLKS_PER_BAUD(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_s (
    .clk_in(clk), .rst_n_in(rst_n), .rx_in(rxl[2]), .data_out(dout[2]), .valid_out(vld[2]),
    .ready_in(rdy[2]), .parity_err_out(perr[2]), .frame_err_out(ferr[2]),
    .overrun_out(ovr[2]), .busy_out(busy[2]));

  // Record every accepted frame and every overrun pulse
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (vld[i] && rdy[i]) begin
        acc[i]     <= acc[i] + 1;
        last_d[i]  <= dout[i];
        last_pe[i] <= perr[i];
        last_fe[i] <= ferr[i];
      end
      if (ovr[i]) ovr_cnt[i] <= ovr_cnt[i] + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Hold one bit value for a full bit period; called and returns at a negedge.
  task automatic drive_bit(input logic v);
    rx_line = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_head(input logic [7:0] d, input logic par_en, input logic par_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (par_en) drive_bit(par_bit);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_en, input logic par_bit,
                            input int nstop);
    send_head(d, par_en, par_bit);
    for (int i = 0; i < nstop; i++) drive_bit(1'b1);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rdy[i] = 1'b0;
      acc[i] = 0;
      ovr_cnt[i] = 0;
    end
    repeat (3) @(negedge clk);
    check_eq("rst_valid", {31'd0, vld[0]}, 32'd0);
    check_eq("rst_busy", {31'd0, busy[0]}, 32'd0);
    check_eq("rst_data", {24'd0, dout[0]}, 32'd0);
    check_eq("rst_ovr", {31'd0, ovr[0]}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Normal 8N1 frame with exact delivery latency
    sel = 0;
    send_head(8'hA5, 1'b0, 1'b0);
    rx_line = 1'b1;
    repeat (12) @(negedge clk);
    check_eq("a5_valid_early", {31'd0, vld[0]}, 32'd0);
    @(negedge clk);
    check_eq("a5_valid", {31'd0, vld[0]}, 32'd1);
    check_eq("a5_data", {24'd0, dout[0]}, 32'hA5);
    check_eq("a5_perr", {31'd0, perr[0]}, 32'd0);
    check_eq("a5_ferr", {31'd0, ferr[0]}, 32'd0);
    rdy[0] = 1'b1;
    @(negedge clk);
    check_eq("a5_valid_clr", {31'd0, vld[0]}, 32'd0);
    check_eq("a5_acc", acc[0], 32'd1);
    repeat (2) @(negedge clk);

    // Start-bit glitch
    a0 = acc[0];
    rx_line = 1'b0;
    repeat (4) @(negedge clk);
    rx_line = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("glitch_busy", {31'd0, busy[0]}, 32'd1);
    repeat (12) @(negedge clk);
    check_eq("glitch_idle", {31'd0, busy[0]}, 32'd0);
    check_eq("glitch_noframe", acc[0], a0);
    send_frame(8'h3C, 1'b0, 1'b0, 1);
    repeat (4) @(negedge clk);
    check_eq("3c_acc", acc[0], a0 + 1);
    check_eq("3c_data", {24'd0, last_d[0]}, 32'h3C);

    // Line held low: one framing-error frame, then a clean one
    a0 = acc[0];
    rx_line = 1'b0;
    repeat (20 * CPB) @(negedge clk);
    rx_line = 1'b1;
    repeat (40) @(negedge clk);
    check_eq("brk_acc", acc[0], a0 + 1);
    check_eq("brk_data", {24'd0, last_d[0]}, 32'h00);
    check_eq("brk_ferr", {31'd0, last_fe[0]}, 32'd1);
    check_eq("brk_idle", {31'd0, busy[0]}, 32'd0);
    send_frame(8'h5A, 1'b0, 1'b0, 1);
    repeat (4) @(negedge clk);
    check_eq("5a_acc", acc[0], a0 + 2);
    check_eq("5a_data", {24'd0, last_d[0]}, 32'h5A);
    check_eq("5a_ferr", {31'd0, last_fe[0]}, 32'd0);

    // Overrun: second frame dropped while first is held
    rdy[0] = 1'b0;
    a0 = acc[0];
    o0 = ovr_cnt[0];
    send_frame(8'h11, 1'b0, 1'b0, 1);
    send_frame(8'h22, 1'b0, 1'b0, 1);
    repeat (4) @(negedge clk);
    check_eq("ovr_valid", {31'd0, vld[0]}, 32'd1);
    check_eq("ovr_data", {24'd0, dout[0]}, 32'h11);
    check_eq("ovr_pulses", ovr_cnt[0], o0 + 1);
    rdy[0] = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("ovr_acc", acc[0], a0 + 1);
    check_eq("ovr_acc_data", {24'd0, last_d[0]}, 32'h11);
    check_eq("ovr_valid_clr", {31'd0, vld[0]}, 32'd0);
    repeat (40) @(negedge clk);
    check_eq("ovr_no22", acc[0], a0 + 1);

    // Delivery in the same cycle as a handshake
    rdy[0] = 1'b0;
    send_frame(8'h33, 1'b0, 1'b0, 1);
    a0 = acc[0];
    o0 = ovr_cnt[0];
    send_head(8'h44, 1'b0, 1'b0);
    rx_line = 1'b1;
    repeat (12) @(negedge clk);
    rdy[0] = 1'b1;
    @(negedge clk);
    rdy[0] = 1'b0;
    check_eq("swap_valid", {31'd0, vld[0]}, 32'd1);
    check_eq("swap_data", {24'd0, dout[0]}, 32'h44);
    check_eq("swap_acc_data", {24'd0, last_d[0]}, 32'h33);
    check_eq("swap_acc", acc[0], a0 + 1);
    repeat (3) @(negedge clk);
    check_eq("swap_no_ovr", ovr_cnt[0], o0);
    rdy[0] = 1'b1;
    repeat (2) @(negedge clk);

    // Even parity
    sel = 1;
    rdy[1] = 1'b1;
    a0 = acc[1];
    send_frame(8'h07, 1'b1, 1'b0, 1);
    repeat (4) @(negedge clk);
    check_eq("par_bad_acc", acc[1], a0 + 1);
    check_eq("par_bad_data", {24'd0, last_d[1]}, 32'h07);
    check_eq("par_bad_perr", {31'd0, last_pe[1]}, 32'd1);
    send_frame(8'h07, 1'b1, 1'b1, 1);
    repeat (4) @(negedge clk);
    check_eq("par_ok_acc", acc[1], a0 + 2);
    check_eq("par_ok_perr", {31'd0, last_pe[1]}, 32'd0);
    check_eq("par_ok_ferr", {31'd0, last_fe[1]}, 32'd0);

    // Async reset during data bit 3, then a 2-stop frame
    sel = 2;
    rdy[2] = 1'b0;
    send_frame(8'h0F, 1'b0, 1'b0, 2);
    check_eq("s2_held", {24'd0, dout[2]}, 32'h0F);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b0);
    rx_line = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("mid_busy", {31'd0, busy[2]}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("arst_valid", {31'd0, vld[2]}, 32'd0);
    check_eq("arst_data", {24'd0, dout[2]}, 32'd0);
    check_eq("arst_busy", {31'd0, busy[2]}, 32'd0);
    rx_line = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    rdy[2] = 1'b1;
    a0 = acc[2];
    send_frame(8'hC3, 1'b0, 1'b0, 2);
    repeat (4) @(negedge clk);
    check_eq("c3_acc", acc[2], a0 + 1);
    check_eq("c3_data", {24'd0, last_d[2]}, 32'hC3);
    check_eq("c3_perr", {31'd0, last_pe[2]}, 32'd0);
    check_eq("c3_ferr", {31'd0, last_fe[2]}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
